// File: rtl/firebird7_in_gate1_tessent_tdr_pkg.sv
// Shared definitions for the gate1 IJTAG override-control TDRs.
package firebird7_in_gate1_tessent_tdr_pkg;

  // Override data width of the w3 control TDR
  localparam int TDR_W3_WIDTH = 3;

  // Field positions inside the w3 shift register (select | sticky | data)
  localparam int SEL_BIT    = TDR_W3_WIDTH + 1;
  localparam int STICKY_BIT = TDR_W3_WIDTH;
  localparam int DATA_LSB   = 0;

  // Update register contents: the fields that leave this block toward the mux
  typedef struct packed {
    logic                    sel;
    logic [TDR_W3_WIDTH-1:0] data;
  } tdr_ur_t;

endpackage

// File: rtl/firebird7_in_gate1_tessent_tdr_w3_ctl.sv
// Gate1 IJTAG TDR driving the control side of a 3-bit data override mux.
// Shift/update pair generates select and data for the mux; capture reads the
// mux output back and a sticky flag records any override readback mismatch.
module firebird7_in_gate1_tessent_tdr_w3_ctl
  import firebird7_in_gate1_tessent_tdr_pkg::*;
#(
  parameter int               WIDTH      = TDR_W3_WIDTH,
  parameter logic [WIDTH-1:0] DATA_RESET = '0
) (
  input  logic             ijtag_tck,
  input  logic             ijtag_reset,
  input  logic             ijtag_sel,
  input  logic             ijtag_ce,
  input  logic             ijtag_se,
  input  logic             ijtag_ue,
  input  logic             ijtag_si,
  output logic             ijtag_so,
  input  logic [WIDTH-1:0] observe_data,
  output logic             ijtag_select,
  output logic [WIDTH-1:0] ijtag_data_in,
  output logic             mismatch
);

  // Field positions scale with WIDTH; they match the package constants at WIDTH=3
  localparam int SR_W       = WIDTH + 2;
  localparam int SR_SEL     = WIDTH + 1;
  localparam int SR_STICKY  = WIDTH;

  logic [SR_W-1:0]  sr_q, sr_d;
  logic             ur_sel_q, ur_sel_d;
  logic [WIDTH-1:0] ur_data_q, ur_data_d;
  logic             mismatch_q, mismatch_d;

  logic do_capture, do_shift, do_update;
  logic mismatch_set;
  logic mismatch_next;

  // Event decode: capture beats shift, update is independent; nothing acts while deselected
  always_comb begin
    do_capture    = ijtag_sel & ijtag_ce;
    do_shift      = ijtag_sel & ijtag_se & ~ijtag_ce;
    do_update     = ijtag_sel & ijtag_ue;
    mismatch_set  = do_capture & ur_sel_q & (observe_data != ur_data_q);
    mismatch_next = mismatch_q | mismatch_set;
  end

  // Shift register next state: capture loads select/sticky/observed data, shift moves toward SO
  always_comb begin
    sr_d = sr_q;
    if (do_capture) begin
      sr_d[SR_SEL]      = ur_sel_q;
      sr_d[SR_STICKY]   = mismatch_next;
      sr_d[WIDTH-1:0]   = observe_data;
    end else if (do_shift) begin
      sr_d = {ijtag_si, sr_q[SR_W-1:1]};
    end
  end

  // Update register next state: takes the pre-edge SR select and data fields
  always_comb begin
    ur_sel_d  = ur_sel_q;
    ur_data_d = ur_data_q;
    if (do_update) begin
      ur_sel_d  = sr_q[SR_SEL];
      ur_data_d = sr_q[WIDTH-1:0];
    end
  end

  // Sticky mismatch: set wins over write-1-to-clear from an update with the sticky bit high
  always_comb begin
    mismatch_d = mismatch_q;
    if (mismatch_set) begin
      mismatch_d = 1'b1;
    end else if (do_update && sr_q[SR_STICKY]) begin
      mismatch_d = 1'b0;
    end
  end

  // Shift register flops
  always_ff @(posedge ijtag_tck or posedge ijtag_reset) begin
    if (ijtag_reset) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  // Update register flops
  always_ff @(posedge ijtag_tck or posedge ijtag_reset) begin
    if (ijtag_reset) begin
      ur_sel_q  <= 1'b0;
      ur_data_q <= DATA_RESET;
    end else begin
      ur_sel_q  <= ur_sel_d;
      ur_data_q <= ur_data_d;
    end
  end

  // Sticky mismatch flop
  always_ff @(posedge ijtag_tck or posedge ijtag_reset) begin
    if (ijtag_reset) begin
      mismatch_q <= 1'b0;
    end else begin
      mismatch_q <= mismatch_d;
    end
  end

  // All outputs come straight from flops
  always_comb begin
    ijtag_so      = sr_q[0];
    ijtag_select  = ur_sel_q;
    ijtag_data_in = ur_data_q;
    mismatch      = mismatch_q;
  end

endmodule

// File: tb/tb_firebird7_in_gate1_tessent_tdr_w3_ctl.sv
// Directed bench for the gate1 w3 override-control TDR.
module tb_firebird7_in_gate1_tessent_tdr_w3_ctl;

  logic       ijtag_tck = 1'b0;
  logic       ijtag_reset;
  logic       ijtag_sel, ijtag_ce, ijtag_se, ijtag_ue, ijtag_si;
  logic       ijtag_so;
  logic [2:0] observe_data;
  logic       ijtag_select;
  logic [2:0] ijtag_data_in;
  logic       mismatch;

  int checks = 0;
  int errors = 0;

  firebird7_in_gate1_tessent_tdr_w3_ctl #(.WIDTH(3), .DATA_RESET(3'b000)) dut (
    .ijtag_tck     (ijtag_tck),
    .ijtag_reset   (ijtag_reset),
    .ijtag_sel     (ijtag_sel),
    .ijtag_ce      (ijtag_ce),
    .ijtag_se      (ijtag_se),
    .ijtag_ue      (ijtag_ue),
    .ijtag_si      (ijtag_si),
    .ijtag_so      (ijtag_so),
    .observe_data  (observe_data),
    .ijtag_select  (ijtag_select),
    .ijtag_data_in (ijtag_data_in),
    .mismatch      (mismatch)
  );

  always #5 ijtag_tck = ~ijtag_tck;

  // one rising edge, then settle 1 time unit past it
  task automatic tick();
    @(posedge ijtag_tck);
    #1;
  endtask

  task automatic idle();
    ijtag_ce = 1'b0; ijtag_se = 1'b0; ijtag_ue = 1'b0; ijtag_si = 1'b0;
  endtask

  // shift a 5-bit word {sel, sticky, data} LSB first; ends with SR == w
  task automatic shift_word(input logic [4:0] w);
    for (int i = 0; i < 5; i++) begin
      ijtag_se = 1'b1; ijtag_si = w[i];
      tick();
    end
    idle();
  endtask

  task automatic test_reset();
    // program something non-default, then reset in the middle of a shift
    shift_word(5'b10111);
    ijtag_ue = 1'b1; tick(); idle();
    ijtag_se = 1'b1; ijtag_si = 1'b1; tick(); tick();
    #2 ijtag_reset = 1'b1;
    #1;
    checks++; if (dut.sr_q !== 5'b00000) begin errors++; $display("FAIL rst_sr got %b want %b", dut.sr_q, 5'b00000); end
    checks++; if (ijtag_select !== 1'b0) begin errors++; $display("FAIL rst_select got %b want 0", ijtag_select); end
    checks++; if (ijtag_data_in !== 3'b000) begin errors++; $display("FAIL rst_data got %b want 000", ijtag_data_in); end
    checks++; if (ijtag_so !== 1'b0) begin errors++; $display("FAIL rst_so got %b want 0", ijtag_so); end
    checks++; if (mismatch !== 1'b0) begin errors++; $display("FAIL rst_mismatch got %b want 0", mismatch); end
    #1 ijtag_reset = 1'b0;
    // first edge after release shifts normally (se/si still high)
    tick(); idle();
    checks++; if (dut.sr_q !== 5'b10000) begin errors++; $display("FAIL rst_first_edge got %b want %b", dut.sr_q, 5'b10000); end
  endtask

  task automatic test_program();
    shift_word(5'b10101);
    checks++; if (ijtag_select !== 1'b0) begin errors++; $display("FAIL prog_pre_update got %b want 0", ijtag_select); end
    ijtag_ue = 1'b1; tick(); idle();
    checks++; if (ijtag_select !== 1'b1) begin errors++; $display("FAIL prog_select got %b want 1", ijtag_select); end
    checks++; if (ijtag_data_in !== 3'b101) begin errors++; $display("FAIL prog_data got %b want 101", ijtag_data_in); end
  endtask

  task automatic test_readback_match();
    logic [4:0] exp_bits;
    exp_bits = 5'b10101;
    observe_data = 3'b101;
    ijtag_ce = 1'b1; tick(); idle();
    checks++; if (dut.sr_q !== 5'b10101) begin errors++; $display("FAIL rb_capture got %b want %b", dut.sr_q, 5'b10101); end
    for (int i = 0; i < 5; i++) begin
      checks++; if (ijtag_so !== exp_bits[i]) begin errors++; $display("FAIL rb_so_bit%0d got %b want %b", i, ijtag_so, exp_bits[i]); end
      ijtag_se = 1'b1; ijtag_si = 1'b0; tick(); idle();
    end
    checks++; if (mismatch !== 1'b0) begin errors++; $display("FAIL rb_mismatch got %b want 0", mismatch); end
  endtask

  task automatic test_mismatch();
    observe_data = 3'b100;
    ijtag_ce = 1'b1; tick(); idle();
    checks++; if (mismatch !== 1'b1) begin errors++; $display("FAIL mm_set got %b want 1", mismatch); end
    checks++; if (dut.sr_q !== 5'b11100) begin errors++; $display("FAIL mm_capture got %b want %b", dut.sr_q, 5'b11100); end
    shift_word(5'b11101);
    checks++; if (mismatch !== 1'b1) begin errors++; $display("FAIL mm_hold_shift got %b want 1", mismatch); end
    ijtag_ue = 1'b1; tick(); idle();
    checks++; if (mismatch !== 1'b0) begin errors++; $display("FAIL mm_clear got %b want 0", mismatch); end
    checks++; if (ijtag_data_in !== 3'b101) begin errors++; $display("FAIL mm_ur_data got %b want 101", ijtag_data_in); end
    // SR still 11101: capture (set) and update (clear) on one edge
    ijtag_ce = 1'b1; ijtag_ue = 1'b1; tick(); idle();
    checks++; if (mismatch !== 1'b1) begin errors++; $display("FAIL mm_set_wins got %b want 1", mismatch); end
    checks++; if (dut.sr_q !== 5'b11100) begin errors++; $display("FAIL mm_set_clear_sr got %b want %b", dut.sr_q, 5'b11100); end
  endtask

  task automatic test_deselect();
    logic [3:0] pat [10];
    pat = '{4'b1111, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0111, 4'b1011, 4'b1101, 4'b1110, 4'b0110};
    ijtag_sel = 1'b0;
    observe_data = 3'b010;
    for (int i = 0; i < 10; i++) begin
      {ijtag_ce, ijtag_se, ijtag_ue, ijtag_si} = pat[i];
      tick();
    end
    idle();
    ijtag_sel = 1'b1;
    checks++; if (dut.sr_q !== 5'b11100) begin errors++; $display("FAIL desel_sr got %b want %b", dut.sr_q, 5'b11100); end
    checks++; if ({ijtag_select, ijtag_data_in} !== 4'b1101) begin errors++; $display("FAIL desel_ur got %b want 1101", {ijtag_select, ijtag_data_in}); end
    checks++; if (mismatch !== 1'b1) begin errors++; $display("FAIL desel_mismatch got %b want 1", mismatch); end
  endtask

  task automatic test_priority();
    shift_word(5'b00110);
    observe_data = 3'b011;
    ijtag_ce = 1'b1; ijtag_se = 1'b1; ijtag_si = 1'b0; tick(); idle();
    checks++; if (dut.sr_q !== 5'b11011) begin errors++; $display("FAIL prio_ce_over_se got %b want %b", dut.sr_q, 5'b11011); end
    observe_data = 3'b101;
    ijtag_ce = 1'b1; ijtag_ue = 1'b1; tick(); idle();
    checks++; if ({ijtag_select, ijtag_data_in} !== 4'b1011) begin errors++; $display("FAIL prio_ue_pre_sr got %b want 1011", {ijtag_select, ijtag_data_in}); end
    checks++; if (mismatch !== 1'b0) begin errors++; $display("FAIL prio_clear got %b want 0", mismatch); end
    checks++; if (dut.sr_q !== 5'b11101) begin errors++; $display("FAIL prio_capture_sr got %b want %b", dut.sr_q, 5'b11101); end
  endtask

  initial begin
    ijtag_reset = 1'b1;
    ijtag_sel = 1'b1;
    observe_data = 3'b000;
    idle();
    tick(); tick();
    ijtag_reset = 1'b0;
    tick();
    checks++; if ({ijtag_so, ijtag_select, ijtag_data_in, mismatch} !== 6'b000000) begin errors++; $display("FAIL init_outputs got %b want 000000", {ijtag_so, ijtag_select, ijtag_data_in, mismatch}); end
    test_reset();
    test_program();
    test_readback_match();
    test_mismatch();
    test_deselect();
    test_priority();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
